// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser: parser states,
// default SOF marker, bit timing and the derived inter-byte timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } parser_state_t;

  localparam logic [7:0]  SOF_DEFAULT     = 8'h55;
  localparam int unsigned CLKS_PER_BIT    = 434;
  localparam int unsigned TIMEOUT_BITS    = 20;
  localparam int unsigned TIMEOUT_DEFAULT = TIMEOUT_BITS * CLKS_PER_BIT;

  // A LEN byte is usable when it names 1..max_len payload bytes.
  function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 memory, one write port, one registered read port.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  // Storage array carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF/LEN/payload/XOR-checksum frames from the uart_rx byte stream.
// Optional inter-byte timeout is enabled with `define UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter  int unsigned MAX_LEN      = 16,
  parameter  logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
  parameter  int unsigned TIMEOUT_CLKS = TIMEOUT_DEFAULT,
  localparam int unsigned AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned LW           = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    i_data,
  input  logic          i_data_available,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_frame_valid,
  output logic [LW-1:0] o_frame_len,
  output logic          o_busy,
  output logic          o_crc_err,
  output logic          o_len_err,
  output logic          o_timeout_err
);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_params
    $error("uart_frame_parser: unsupported parameter values");
  end

  parser_state_t state_q;
  logic [LW-1:0] len_q;
  logic [7:0]    acc_q;
  logic [AW-1:0] idx_q;
  logic          frame_valid_q;
  logic [LW-1:0] frame_len_q;
  logic          busy_q;
  logic          crc_err_q;
  logic          len_err_q;
  logic          tmo_err_q;
  logic          tmo_hit_c;
  logic          buf_we_c;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS);

  logic [TW-1:0] tmo_cnt_q;

  assign tmo_hit_c = (state_q != HUNT) && !i_data_available &&
                     (tmo_cnt_q == TW'(TIMEOUT_CLKS - 1));

  // Inter-byte gap counter; idle in HUNT, restarted by every received byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == HUNT || i_data_available || tmo_hit_c) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  assign buf_we_c = i_data_available && (state_q == PAYLOAD);

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (buf_we_c),
    .waddr   (idx_q),
    .wdata   (i_data),
    .raddr   (i_rd_addr),
    .rd_data (o_rd_data)
  );

  // Frame FSM; result/error pulses are cleared every cycle unless re-raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      len_q         <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      busy_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      tmo_err_q     <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      tmo_err_q     <= 1'b0;
      if (i_data_available) begin
        unique case (state_q)
          HUNT: begin
            if (i_data == SOF_BYTE) begin
              state_q <= LEN;
              busy_q  <= 1'b1;
            end
          end
          LEN: begin
            if (len_ok(i_data, MAX_LEN)) begin
              len_q   <= LW'(i_data);
              acc_q   <= i_data;
              idx_q   <= '0;
              state_q <= PAYLOAD;
            end else begin
              len_err_q <= 1'b1;
              state_q   <= HUNT;
              busy_q    <= 1'b0;
            end
          end
          PAYLOAD: begin
            acc_q <= acc_q ^ i_data;
            idx_q <= idx_q + AW'(1);
            if (LW'(idx_q) == len_q - LW'(1)) begin
              state_q <= CHK;
            end
          end
          CHK: begin
            if (i_data == acc_q) begin
              frame_valid_q <= 1'b1;
              frame_len_q   <= len_q;
            end else begin
              crc_err_q <= 1'b1;
            end
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (tmo_hit_c) begin
        tmo_err_q <= 1'b1;
        state_q   <= HUNT;
        busy_q    <= 1'b0;
      end
    end
  end

  assign o_frame_valid = frame_valid_q;
  assign o_frame_len   = frame_len_q;
  assign o_busy        = busy_q;
  assign o_crc_err     = crc_err_q;
  assign o_len_err     = len_err_q;
  assign o_timeout_err = tmo_err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames plus random byte streams checked
// every cycle against a queue-based frame model.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned LW      = 5;
  localparam int unsigned TMO     = 8680;
  localparam logic [7:0]  SOF     = 8'h55;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    i_data = 8'h00;
  logic          i_data_available = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic [7:0]    o_rd_data;
  logic          o_frame_valid;
  logic [LW-1:0] o_frame_len;
  logic          o_busy;
  logic          o_crc_err;
  logic          o_len_err;
  logic          o_timeout_err;

  uart_frame_parser dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_data           (i_data),
    .i_data_available (i_data_available),
    .i_rd_addr        (i_rd_addr),
    .o_rd_data        (o_rd_data),
    .o_frame_valid    (o_frame_valid),
    .o_frame_len      (o_frame_len),
    .o_busy           (o_busy),
    .o_crc_err        (o_crc_err),
    .o_len_err        (o_len_err),
    .o_timeout_err    (o_timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_tmo   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: bytes of the frame in progress kept in a queue, decided by frame rules.
  logic [7:0]    cur[$];
  logic [7:0]    mbuf [MAX_LEN];
  logic          exp_valid, exp_crc, exp_len, exp_tmo, exp_busy, clean, rd_ok;
  logic [LW-1:0] exp_flen;
  logic [7:0]    exp_rd, xsum;
  int            gap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur.delete();
      exp_valid = 0; exp_crc = 0; exp_len = 0; exp_tmo = 0; exp_busy = 0;
      exp_flen = '0; clean = 0; rd_ok = 0; exp_rd = 8'h00; gap = 0;
    end else begin
      rd_ok  = clean && !exp_busy && (int'(i_rd_addr) < int'(exp_flen));
      exp_rd = mbuf[i_rd_addr];
      exp_valid = 0; exp_crc = 0; exp_len = 0; exp_tmo = 0;
      if (i_data_available) begin
        gap = 0;
        if (cur.size() != 0 || i_data == SOF) cur.push_back(i_data);
        if (cur.size() == 2 && (i_data == 8'h00 || int'(i_data) > MAX_LEN)) begin
          exp_len = 1;
          cur.delete();
        end else if (cur.size() >= 3) begin
          if (cur.size() < int'(cur[1]) + 3) begin
            clean = 0;
          end else begin
            xsum = 8'h00;
            for (int i = 1; i < cur.size() - 1; i++) xsum ^= cur[i];
            if (xsum == i_data) begin
              exp_valid = 1;
              exp_flen  = LW'(cur[1]);
              for (int i = 0; i < int'(cur[1]); i++) mbuf[i] = cur[i+2];
              clean = 1;
            end else begin
              exp_crc = 1;
            end
            cur.delete();
          end
        end
      end else if (cur.size() != 0) begin
        gap++;
`ifdef UART_FRAME_TIMEOUT_EN
        if (gap == TMO) begin
          exp_tmo = 1;
          cur.delete();
          gap = 0;
        end
`endif
      end
      exp_busy = (cur.size() != 0);
    end
  end

  always @(negedge clk) begin
    chk("frame_valid", 32'(o_frame_valid), 32'(exp_valid));
    chk("crc_err", 32'(o_crc_err), 32'(exp_crc));
    chk("len_err", 32'(o_len_err), 32'(exp_len));
    chk("timeout_err", 32'(o_timeout_err), 32'(exp_tmo));
    chk("busy", 32'(o_busy), 32'(exp_busy));
    chk("frame_len", 32'(o_frame_len), 32'(exp_flen));
    if (rd_ok) chk("rd_data", 32'(o_rd_data), 32'(exp_rd));
    if (o_frame_valid) n_valid++;
    if (o_timeout_err) n_tmo++;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    i_data = b;
    i_data_available = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      i_data_available = 1'b0;
    end
  endtask

  task automatic read_check(input logic [AW-1:0] a, input logic [7:0] exp);
    @(negedge clk); #1;
    i_data_available = 1'b0;
    i_rd_addr = a;
    @(negedge clk);
    chk("rd_lit", 32'(o_rd_data), 32'(exp));
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    i_data_available = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out", {o_frame_valid, o_crc_err, o_len_err, o_timeout_err, o_busy,
                    3'b000, o_rd_data, 3'b000, o_frame_len}, 32'h0);
    #1 rst_n = 1'b1;
  endtask

  // Sends the byte list, then checks the result pulse in the following cycle.
  task automatic send_frame(input logic [7:0] bytes[$], input string name,
                            input logic [2:0] exp_vcl, input logic [LW-1:0] exp_l);
    foreach (bytes[i]) send(bytes[i]);
    @(negedge clk);
    chk({name, "_pulse"}, 32'({o_frame_valid, o_crc_err, o_len_err}), 32'(exp_vcl));
    chk({name, "_len"}, 32'(o_frame_len), 32'(exp_l));
    #1 i_data_available = 1'b0;
  endtask

  initial begin
    int v0, t0, kind, n;
    logic [7:0] b, x;
    logic [7:0] fr[$];

    repeat (3) @(negedge clk);
    chk("rst_init", {o_frame_valid, o_crc_err, o_len_err, o_timeout_err, o_busy,
                     3'b000, o_rd_data, 3'b000, o_frame_len}, 32'h0);
    #1 rst_n = 1'b1;
    idle(2);

    send_frame('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, "good", 3'b100, 5'd3);
    read_check(4'd0, 8'h11);
    read_check(4'd1, 8'h22);
    read_check(4'd2, 8'h33);
    send_frame('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04}, "badcrc", 3'b010, 5'd3);
    send_frame('{8'h55, 8'h00}, "len0", 3'b001, 5'd3);
    send_frame('{8'h55, 8'h11}, "len17", 3'b001, 5'd3);
    send_frame('{8'h55, 8'h01, 8'hA5, 8'hA4}, "after_len", 3'b100, 5'd1);
    read_check(4'd0, 8'hA5);

    v0 = n_valid;
    foreach (fr[i]) fr.delete();
    fr = '{8'h00, 8'hFF, 8'h55, 8'h01, 8'hA5, 8'hA4, 8'h55, 8'h01, 8'h5A, 8'h5B};
    foreach (fr[i]) send(fr[i]);
    idle(2);
    chk("b2b_count", 32'(n_valid - v0), 32'd2);
    chk("b2b_len", 32'(o_frame_len), 32'd1);
    read_check(4'd0, 8'h5A);

    for (int f = 0; f < 400; f++) begin
      kind = $urandom_range(0, 9);
      fr.delete();
      if (kind <= 6) begin
        n = $urandom_range(1, MAX_LEN);
        fr.push_back(SOF);
        fr.push_back(8'(n));
        x = 8'(n);
        for (int i = 0; i < n; i++) begin
          b = ($urandom_range(0, 7) == 0) ? SOF : 8'($urandom);
          fr.push_back(b);
          x ^= b;
        end
        if (kind == 6) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end else if (kind == 7) begin
        fr.push_back(SOF);
        fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else if (kind == 8) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom);
          if (b == SOF) b = 8'h00;
          fr.push_back(b);
        end
      end else begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      end
      foreach (fr[i]) begin
        i_rd_addr = AW'($urandom);
        send(fr[i]);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(2);
    apply_reset();
    idle(2);

    t0 = n_tmo;
    send(8'h55); send(8'h02); send(8'hAA);
    idle(TMO + 5);
`ifdef UART_FRAME_TIMEOUT_EN
    chk("tmo_count", 32'(n_tmo - t0), 32'd1);
    chk("tmo_busy", 32'(o_busy), 32'd0);
    send_frame('{8'h55, 8'h01, 8'hA5, 8'hA4}, "after_tmo", 3'b100, 5'd1);
`else
    chk("notmo_count", 32'(n_tmo - t0), 32'd0);
    chk("notmo_busy", 32'(o_busy), 32'd1);
`endif

    apply_reset();
    send(8'h55); send(8'h02); send(8'hAA);
    idle(1);
    chk("midframe_busy", 32'(o_busy), 32'd1);
    apply_reset();
    send_frame('{8'h55, 8'h01, 8'hA5, 8'hA4}, "after_rst", 3'b100, 5'd1);
    read_check(4'd0, 8'hA5);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
